pll_reset_sequencer: RTL and testbench

//   Drives the reset input of the system PLL and consumes its lock output.

---
 rtl/pll_reset_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pll_reset_sequencer                                           |
// | Purpose  : Pulses the system PLL reset, waits for (and qualifies) lock,  |
// |            then releases per-domain resets in staged order. Lock loss    |
// |            after release has begun re-runs the whole sequence and is     |
// |            recorded in a sticky flag and a saturating counter.           |
// |            Clocked by the free-running reference clock so it keeps       |
// |            working while the PLL is unlocked.                            |
// | Ports    : refclk_i      free-running reference clock                    |
// |            rst_i         asynchronous active-high reset                  |
// |            pll_locked_i  PLL lock, asynchronous to refclk_i              |
// |            clr_status_i  synchronous clear of lock_lost_o/loss_count_o   |
// |            pll_rst_o     active-high reset to the PLL                    |
// |            domain_rst_o  per-domain active-high resets (index 0 first)   |
// |            ready_o       all domains released, PLL locked                |
// |            lock_lost_o   sticky lock-loss flag                           |
// |            loss_count_o  saturating lock-loss event count                |
// |            state_dbg_o   current FSM state encoding                      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int LOCK_STABLE    = 1024,
  parameter int NUM_DOMAINS    = 3,
  parameter int STAGE_GAP      = 64,
  parameter int CNT_W          = 8
) (
  input  logic                   refclk_i,
  input  logic                   rst_i,
  input  logic                   pll_locked_i,
  input  logic                   clr_status_i,
  output logic                   pll_rst_o,
  output logic [NUM_DOMAINS-1:0] domain_rst_o,
  output logic                   ready_o,
  output logic                   lock_lost_o,
  output logic [CNT_W-1:0]       loss_count_o,
  output logic [2:0]             state_dbg_o
);

  // One shared cycle counter serves every timed state, so it is sized for
  // the largest interval any state has to measure.
  localparam int c_MAX_AB  = (LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE;
  localparam int c_MAX_CD  = (STAGE_GAP > PLL_RST_CYCLES) ? STAGE_GAP : PLL_RST_CYCLES;
  localparam int c_CNT_MAX = (c_MAX_AB > c_MAX_CD) ? c_MAX_AB : c_MAX_CD;
  localparam int c_TW      = $clog2(c_CNT_MAX + 1);
  localparam int c_SW      = $clog2(NUM_DOMAINS + 1);

  localparam logic [c_TW-1:0]  c_TMR_ONE  = c_TW'(1);
  localparam logic [c_TW-1:0]  c_RST_LAST = c_TW'(PLL_RST_CYCLES - 1);
  localparam logic [c_TW-1:0]  c_TMO_LAST = c_TW'(LOCK_TIMEOUT - 1);
  localparam logic [c_TW-1:0]  c_STB_LAST = c_TW'(LOCK_STABLE - 1);
  localparam logic [c_TW-1:0]  c_GAP_LAST = c_TW'(STAGE_GAP - 1);
  localparam logic [c_SW-1:0]  c_STG_ONE  = c_SW'(1);
  localparam logic [c_SW-1:0]  c_STG_ALL  = c_SW'(NUM_DOMAINS);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_SAT  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_SETTLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  // Lock synchronizer
  logic lock_m_q;
  logic lock_s_q;

  // FSM and registered outputs
  state_t                 state_q,      state_d;
  logic [c_TW-1:0]        tmr_q,        tmr_d;
  logic [c_SW-1:0]        stage_q,      stage_d;   // domains released so far
  logic                   pll_rst_q,    pll_rst_d;
  logic [NUM_DOMAINS-1:0] domain_rst_q, domain_rst_d;
  logic                   ready_q,      ready_d;
  logic                   lock_lost_q,  lock_lost_d;
  logic [CNT_W-1:0]       loss_cnt_q,   loss_cnt_d;
  logic                   loss_d;

  // pll_locked_i is asynchronous to refclk_i; two flops before any use.
  always_ff @(posedge refclk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_m_q <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      lock_m_q <= pll_locked_i;
      lock_s_q <= lock_m_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    stage_d      = stage_q;
    pll_rst_d    = pll_rst_q;
    domain_rst_d = domain_rst_q;
    ready_d      = ready_q;
    lock_lost_d  = lock_lost_q;
    loss_cnt_d   = loss_cnt_q;
    loss_d       = 1'b0;

    case (state_q)
      // Lock is deliberately ignored while the PLL is held in reset.
      S_PLL_RST: begin
        if (tmr_q == c_RST_LAST) begin
          state_d   = S_WAIT_LOCK;
          tmr_d     = '0;
          pll_rst_d = 1'b0;
        end else begin
          tmr_d = tmr_q + c_TMR_ONE;
        end
      end

      S_WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = S_SETTLE;
          tmr_d   = '0;
        end else if (tmr_q == c_TMO_LAST) begin
          state_d   = S_PLL_RST;
          tmr_d     = '0;
          pll_rst_d = 1'b1;
        end else begin
          tmr_d = tmr_q + c_TMR_ONE;
        end
      end

      // Lock has to hold for an unbroken run; a dropout before release
      // simply restarts qualification and is not treated as a loss.
      S_SETTLE: begin
        if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
          tmr_d   = '0;
        end else if (tmr_q == c_STB_LAST) begin
          state_d         = S_RELEASE;
          tmr_d           = '0;
          stage_d         = c_STG_ONE;
          domain_rst_d[0] = 1'b0;
        end else begin
          tmr_d = tmr_q + c_TMR_ONE;
        end
      end

      // stage_q names the next domain to release; once it equals
      // NUM_DOMAINS the last release has happened and ready follows.
      S_RELEASE: begin
        if (!lock_s_q) begin
          loss_d = 1'b1;
        end else if (stage_q == c_STG_ALL) begin
          state_d = S_RUN;
          tmr_d   = '0;
          ready_d = 1'b1;
        end else if (tmr_q == c_GAP_LAST) begin
          tmr_d   = '0;
          stage_d = stage_q + c_STG_ONE;
          for (int k = 0; k < NUM_DOMAINS; k++) begin
            if (stage_q == c_SW'(k)) begin
              domain_rst_d[k] = 1'b0;
            end
          end
        end else begin
          tmr_d = tmr_q + c_TMR_ONE;
        end
      end

      S_RUN: begin
        if (!lock_s_q) begin
          loss_d = 1'b1;
        end
      end

      default: begin
        state_d      = S_PLL_RST;
        tmr_d        = '0;
        stage_d      = '0;
        pll_rst_d    = 1'b1;
        domain_rst_d = '1;
        ready_d      = 1'b0;
      end
    endcase

    // Lock loss after release started: reassert every domain together and
    // restart from a fresh PLL reset pulse.
    if (loss_d) begin
      state_d      = S_PLL_RST;
      tmr_d        = '0;
      stage_d      = '0;
      pll_rst_d    = 1'b1;
      domain_rst_d = '1;
      ready_d      = 1'b0;
    end

    // A loss in the same cycle as a clear is still reported, counted as the
    // first event after the clear.
    if (loss_d) begin
      lock_lost_d = 1'b1;
      if (clr_status_i) begin
        loss_cnt_d = c_CNT_ONE;
      end else if (loss_cnt_q != c_CNT_SAT) begin
        loss_cnt_d = loss_cnt_q + c_CNT_ONE;
      end
    end else if (clr_status_i) begin
      lock_lost_d = 1'b0;
      loss_cnt_d  = '0;
    end
  end

  always_ff @(posedge refclk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_PLL_RST;
      tmr_q        <= '0;
      stage_q      <= '0;
      pll_rst_q    <= 1'b1;
      domain_rst_q <= '1;
      ready_q      <= 1'b0;
      lock_lost_q  <= 1'b0;
      loss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      stage_q      <= stage_d;
      pll_rst_q    <= pll_rst_d;
      domain_rst_q <= domain_rst_d;
      ready_q      <= ready_d;
      lock_lost_q  <= lock_lost_d;
      loss_cnt_q   <= loss_cnt_d;
    end
  end

  assign pll_rst_o    = pll_rst_q;
  assign domain_rst_o = domain_rst_q;
  assign ready_o      = ready_q;
  assign lock_lost_o  = lock_lost_q;
  assign loss_count_o = loss_cnt_q;
  assign state_dbg_o  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pll_reset_sequencer                                        |
// | Purpose  : Self-checking bench for pll_reset_sequencer. Expected outputs |
// |            come from a timestamp-based reference model and are queued;   |
// |            a monitor compares them against the DUT every cycle.          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_pll_reset_sequencer;

  localparam int PRC = 4;
  localparam int TMO = 32;
  localparam int STB = 8;
  localparam int GAP = 2;
  localparam int ND  = 3;
  localparam int CW  = 2;

  localparam int P_PULSE  = 0;
  localparam int P_WAIT   = 1;
  localparam int P_SETTLE = 2;
  localparam int P_REL    = 3;
  localparam int P_RUN    = 4;

  logic          clk = 1'b0;
  logic          clk_en = 1'b1;
  logic          rst;
  logic          locked;
  logic          clr;
  logic          pll_rst;
  logic [ND-1:0] dom_rst;
  logic          ready;
  logic          lost;
  logic [CW-1:0] lcount;
  logic [2:0]    st;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES (PRC),
    .LOCK_TIMEOUT   (TMO),
    .LOCK_STABLE    (STB),
    .NUM_DOMAINS    (ND),
    .STAGE_GAP      (GAP),
    .CNT_W          (CW)
  ) dut (
    .refclk_i     (clk),
    .rst_i        (rst),
    .pll_locked_i (locked),
    .clr_status_i (clr),
    .pll_rst_o    (pll_rst),
    .domain_rst_o (dom_rst),
    .ready_o      (ready),
    .lock_lost_o  (lost),
    .loss_count_o (lcount),
    .state_dbg_o  (st)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  typedef struct {
    int pll_rst;
    int dom;
    int ready;
    int lost;
    int cnt;
    int st;
    int edge_no;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: a phase plus the edge at which it was entered. Output
  // expectations are derived from elapsed edges, not from a cycle counter.
  int m_phase, m_t0, m_trel, m_edge, m_count;
  bit m_lost, m_s1, m_s2;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_PULSE; m_t0 = 0; m_trel = 0; m_edge = 0;
    m_count = 0; m_lost = 0; m_s1 = 0; m_s2 = 0;
  endtask

  function automatic bit predict_loss();
    return (m_phase == P_REL || m_phase == P_RUN) && !m_s2;
  endfunction

  task automatic enter(input int ph);
    m_phase = ph;
    m_t0    = m_edge;
  endtask

  task automatic model_step(input bit lk, input bit cl);
    bit   ls;
    bit   loss;
    exp_t e;
    m_edge++;
    ls   = m_s2;       // lock as seen by the FSM: input from two edges ago
    m_s2 = m_s1;
    m_s1 = lk;
    loss = 0;
    case (m_phase)
      P_PULSE:  if (m_edge - m_t0 == PRC) enter(P_WAIT);
      P_WAIT:   if (ls) enter(P_SETTLE); else if (m_edge - m_t0 == TMO) enter(P_PULSE);
      P_SETTLE: if (!ls) enter(P_WAIT);
                else if (m_edge - m_t0 == STB) begin enter(P_REL); m_trel = m_edge; end
      P_REL:    if (!ls) loss = 1; else if (m_edge == m_trel + (ND-1)*GAP + 1) enter(P_RUN);
      default:  if (!ls) loss = 1;
    endcase
    if (loss) begin
      enter(P_PULSE);
      m_lost  = 1;
      m_count = cl ? 1 : ((m_count < (1 << CW) - 1) ? m_count + 1 : m_count);
    end else if (cl) begin
      m_lost  = 0;
      m_count = 0;
    end
    e.pll_rst = (m_phase == P_PULSE) ? 1 : 0;
    e.dom = 0;
    for (int k = 0; k < ND; k++) begin
      if (!((m_phase == P_REL || m_phase == P_RUN) && m_edge >= m_trel + k*GAP))
        e.dom = e.dom | (1 << k);
    end
    e.ready   = (m_phase == P_RUN) ? 1 : 0;
    e.lost    = m_lost ? 1 : 0;
    e.cnt     = m_count;
    e.st      = m_phase;
    e.edge_no = m_edge;
    sb_q.push_back(e);
  endtask

  task automatic drive(input bit lk, input bit cl);
    locked = lk;
    clr    = cl;
    model_step(lk, cl);
    @(negedge clk);
  endtask

  task automatic run_until(input int ph, input bit lk, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (m_phase == ph) return;
      drive(lk, 1'b0);
    end
    if (m_phase != ph) begin
      checks++;
      errors++;
      $display("FAIL reach_phase: got %0d expected %0d", m_phase, ph);
    end
  endtask

  task automatic loss_event(input bit clr_on_loss);
    run_until(P_RUN, 1'b1, 100);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, clr_on_loss && predict_loss());
      if (m_phase == P_PULSE) break;
    end
  endtask

  // Monitor: compare DUT outputs one time unit after each active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check($sformatf("pll_rst@%0d", e.edge_no),    int'(pll_rst), e.pll_rst);
        check($sformatf("domain_rst@%0d", e.edge_no), int'(dom_rst), e.dom);
        check($sformatf("ready@%0d", e.edge_no),      int'(ready),   e.ready);
        check($sformatf("lock_lost@%0d", e.edge_no),  int'(lost),    e.lost);
        check($sformatf("loss_count@%0d", e.edge_no), int'(lcount),  e.cnt);
        check($sformatf("state_dbg@%0d", e.edge_no),  int'(st),      e.st);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit lk;
    int len;
    rst = 1'b1; locked = 1'b0; clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Power-up: lock arrives at cycle 10 and the full release follows.
    repeat (10) drive(1'b0, 1'b0);
    run_until(P_RUN, 1'b1, 60);
    repeat (5) drive(1'b1, 1'b0);

    // Loss in RUN, then a 3-cycle glitch 4 cycles into SETTLE.
    loss_event(1'b0);
    run_until(P_SETTLE, 1'b1, 60);
    repeat (4) drive(1'b1, 1'b0);
    repeat (3) drive(1'b0, 1'b0);
    run_until(P_RUN, 1'b1, 80);

    // Lock held low: loss, then repeated timeout re-pulses.
    repeat (90) drive(1'b0, 1'b0);

    // Drive the counter into saturation, then clear coincident with a loss.
    repeat (5) loss_event(1'b0);
    loss_event(1'b1);
    repeat (3) drive(1'b1, 1'b0);

    // Randomized lock waveform with occasional status clears.
    for (int seg = 0; seg < 40; seg++) begin
      lk  = ($urandom_range(0, 3) != 0);
      len = lk ? $urandom_range(1, 40) : $urandom_range(1, 12);
      if ($urandom_range(0, 9) == 0) len = $urandom_range(30, 80);
      for (int c = 0; c < len; c++) drive(lk, ($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset mid-RELEASE with the clock stopped.
    run_until(P_REL, 1'b1, 200);
    drive(1'b1, 1'b0);
    clk_en = 1'b0;
    #20;
    rst = 1'b1;
    #1;
    check("async_pll_rst",    int'(pll_rst), 1);
    check("async_domain_rst", int'(dom_rst), (1 << ND) - 1);
    check("async_ready",      int'(ready),   0);
    check("async_lock_lost",  int'(lost),    0);
    check("async_loss_count", int'(lcount),  0);
    check("async_state",      int'(st),      P_PULSE);
    #20;
    rst = 1'b0;
    model_reset();
    clk_en = 1'b1;
    repeat (10) drive(1'b0, 1'b0);
    run_until(P_RUN, 1'b1, 60);
    repeat (3) drive(1'b1, 1'b0);

    @(posedge clk);
    #2;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
